dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between the core load/store path and a DMA/debug loader port.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/arb_credit_counter.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM state codes, owner ids
// and the width of the DMA-fairness credit counter.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CORE     = 2'd1;
    localparam logic [1:0] ST_DMA      = 2'd2;
    localparam logic [1:0] ST_DMA_LOCK = 2'd3;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // Wide enough for the largest burst limit (15).
    localparam int CREDIT_W = 4;

endpackage

// File: rtl/arb_credit_counter.sv
// Saturating count of consecutive core grants taken while the DMA port waits;
// at_limit tells the arbiter the DMA port must win the next contested cycle.
module arb_credit_counter
    import dmem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic [CREDIT_W-1:0] limit,
    output logic                at_limit
);

    logic [CREDIT_W-1:0] credit_q, credit_d;

    // NOTE: credit_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        credit_d = credit_q;
        if (clr) begin
            credit_d = '0;
        end else if (inc && (credit_q < limit)) begin
            credit_d = credit_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign at_limit = (credit_q == limit);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core load/store path and a
// DMA/debug loader. Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_core_stalls,
    output logic [15:0]   stat_dma_grants
`endif
);

    localparam logic [CREDIT_W-1:0] BURST_LIMIT = CREDIT_W'(MAX_BURST);

    logic [1:0]    state_q, state_d;
    logic          owner;
    logic          core_win, dma_win;
    logic          credit_inc, credit_clr, at_limit;
    logic          core_rvalid_q, dma_rvalid_q;
    logic [DW-1:0] core_rdata_q, dma_rdata_q;

    arb_credit_counter u_credit (
        .clk      (clk),
        .reset    (reset),
        .inc      (credit_inc),
        .clr      (credit_clr),
        .limit    (BURST_LIMIT),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d    = state_q;
        owner      = OWN_CORE;
        core_win   = 1'b0;
        dma_win    = 1'b0;
        credit_inc = 1'b0;
        credit_clr = 1'b0;
        if (state_q == ST_DMA_LOCK) begin
            owner      = OWN_DMA;
            dma_win    = dma_req;
            credit_clr = 1'b1;
            state_d    = dma_lock ? ST_DMA_LOCK : ST_IDLE;
        end else if (core_req && !(dma_req && at_limit)) begin
            core_win   = 1'b1;
            state_d    = ST_CORE;
            credit_inc = dma_req;
            credit_clr = !dma_req;
        end else if (dma_req) begin
            owner      = OWN_DMA;
            dma_win    = 1'b1;
            credit_clr = 1'b1;
            state_d    = dma_lock ? ST_DMA_LOCK : ST_DMA;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // reset is active-low: while it is held every output is forced to 0 at once.
    assign core_stall = reset & core_req & ~core_win;
    assign dma_gnt    = reset & dma_win;
    assign mem_we     = reset & ((core_win & core_we) | (dma_win & dma_we));
    assign mem_addr   = !reset ? '0 : (owner == OWN_DMA) ? dma_addr : core_addr;
    assign mem_wdata  = !reset ? '0 : (owner == OWN_DMA) ? dma_wdata : core_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            core_rvalid_q <= core_win & ~core_we;
            dma_rvalid_q  <= dma_win & ~dma_we;
            if (core_win && !core_we) core_rdata_q <= mem_rdata;
            if (dma_win && !dma_we)   dma_rdata_q  <= mem_rdata;
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign dma_rdata   = dma_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, gnt_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            if (core_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (dma_gnt && (gnt_cnt_q != 16'hFFFF))      gnt_cnt_q   <= gnt_cnt_q + 16'd1;
        end
    end

    assign stat_core_stalls = stall_cnt_q;
    assign stat_dma_grants  = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a combinational-read memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_stall, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_core_stalls, stat_dma_grants;
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    dmem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_core_stalls(stat_core_stalls), .stat_dma_grants(stat_dma_grants)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic apply_reset();
        reset = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        step();
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        dma_req = 1; dma_we = 1; dma_addr = 32'h60; core_req = 1; core_addr = 32'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0) $display("FAIL rst_hold_dma_gnt: got %b expected 0", dma_gnt); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_hold_mem_we: got %b expected 0", mem_we); else passed++;
        total++; if (core_rvalid !== 1'b0 || dma_rvalid !== 1'b0)
            $display("FAIL rst_hold_rvalid: got %b/%b expected 0/0", core_rvalid, dma_rvalid); else passed++;
        reset = 1;
        step();
        // Core load to 0x20 granted in the first cycle after release (credit 0 < limit).
        total++; if (core_rvalid !== 1'b1) $display("FAIL rst_pre_rvalid: got %b expected 1", core_rvalid); else passed++;
        #2 reset = 0;
        #1;
        total++; if (core_rvalid !== 1'b0) $display("FAIL rst_async_rvalid: got %b expected 0", core_rvalid); else passed++;
        total++; if (core_rdata !== 32'h0) $display("FAIL rst_async_rdata: got %h expected 00000000", core_rdata); else passed++;
        total++; if (mem_we !== 1'b0 || dma_gnt !== 1'b0 || core_stall !== 1'b0)
            $display("FAIL rst_async_ctrl: got we=%b gnt=%b stall=%b expected 0/0/0", mem_we, dma_gnt, core_stall); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rst_async_addr: got %h expected 00000000", mem_addr); else passed++;
        @(negedge clk);
        reset = 1;
        idle_inputs();
        core_req = 1; core_addr = 32'h10;
        #1;
        total++; if (mem_addr !== 32'h10) $display("FAIL rst_release_addr: got %h expected 00000010", mem_addr); else passed++;
        total++; if (core_stall !== 1'b0) $display("FAIL rst_release_stall: got %b expected 0", core_stall); else passed++;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_core_load();
        core_req = 1; core_we = 0; core_addr = 32'h20;
        @(negedge clk);
        total++; if (mem_addr !== 32'h20 || mem_we !== 1'b0 || core_stall !== 1'b0)
            $display("FAIL load_issue: got addr=%h we=%b stall=%b expected 00000020/0/0", mem_addr, mem_we, core_stall); else passed++;
        step();
        idle_inputs();
        @(negedge clk);
        total++; if (core_rvalid !== 1'b1) $display("FAIL load_rvalid: got %b expected 1", core_rvalid); else passed++;
        total++; if (core_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h expected deadbeef", core_rdata); else passed++;
        step();
        @(negedge clk);
        total++; if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEADBEEF)
            $display("FAIL load_hold: got rvalid=%b rdata=%h expected 0/deadbeef", core_rvalid, core_rdata); else passed++;
        dma_req = 1; dma_addr = 32'h24;
        #1;
        total++; if (dma_gnt !== 1'b1) $display("FAIL dma_read_gnt: got %b expected 1", dma_gnt); else passed++;
        step();
        idle_inputs();
        core_req = 1; core_we = 1; core_addr = 32'h28; core_wdata = 32'h12345678;
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hCAFEF00D)
            $display("FAIL dma_read_data: got rvalid=%b rdata=%h expected 1/cafef00d", dma_rvalid, dma_rdata); else passed++;
        step();
        idle_inputs();
        @(negedge clk);
        total++; if (core_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %b expected 0", core_rvalid); else passed++;
        total++; if (mem[32'h28 >> 2] !== 32'h12345678) $display("FAIL store_lands: got %h expected 12345678", mem[32'h28 >> 2]); else passed++;
        step();
    endtask

    task automatic test_fairness();
        logic exp_dma;
        apply_reset();
        core_req = 1; core_addr = 32'h30;
        dma_req = 1; dma_addr = 32'h34;
        for (int i = 0; i < 10; i++) begin
            exp_dma = ((i % 5) == 4);
            @(negedge clk);
            total++; if (dma_gnt !== exp_dma) $display("FAIL fair_gnt[%0d]: got %b expected %b", i, dma_gnt, exp_dma); else passed++;
            total++; if (core_stall !== exp_dma) $display("FAIL fair_stall[%0d]: got %b expected %b", i, core_stall, exp_dma); else passed++;
            total++; if (mem_addr !== (exp_dma ? 32'h34 : 32'h30))
                $display("FAIL fair_addr[%0d]: got %h expected %h", i, mem_addr, exp_dma ? 32'h34 : 32'h30); else passed++;
            step();
        end
`ifdef DMEM_ARB_STATS_EN
        total++; if (stat_dma_grants !== 16'd2) $display("FAIL stat_dma_grants: got %0d expected 2", stat_dma_grants); else passed++;
        total++; if (stat_core_stalls !== 16'd2) $display("FAIL stat_core_stalls: got %0d expected 2", stat_core_stalls); else passed++;
`endif
    endtask

    task automatic test_dma_lock();
        int stalls = 0;
        logic [31:0] a;
        core_req = 1; core_we = 0; core_addr = 32'h50;
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hA0A0_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (core_stall) stalls++;
            total++; if (dma_gnt !== 1'b0) $display("FAIL lock_wait_gnt[%0d]: got %b expected 0", i, dma_gnt); else passed++;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(4 * i);
            dma_addr = a; dma_wdata = 32'hA0A0_0000 + 32'(i); dma_lock = (i < 2);
            @(negedge clk);
            if (core_stall) stalls++;
            total++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a)
                $display("FAIL lock_write[%0d]: got gnt=%b we=%b addr=%h expected 1/1/%h", i, dma_gnt, mem_we, mem_addr, a); else passed++;
            step();
        end
        dma_req = 0; dma_lock = 0; dma_we = 0;
        @(negedge clk);
        if (core_stall) stalls++;
        total++; if (mem_addr !== 32'h50) $display("FAIL lock_release_addr: got %h expected 00000050", mem_addr); else passed++;
        step();
        idle_inputs();
        total++; if (stalls != 3) $display("FAIL lock_stall_count: got %0d expected 3", stalls); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (mem[(32'h100 >> 2) + i] !== 32'hA0A0_0000 + 32'(i))
                $display("FAIL lock_mem[%0d]: got %h expected %h", i, mem[(32'h100 >> 2) + i], 32'hA0A0_0000 + 32'(i)); else passed++;
        end
    endtask

    task automatic test_lock_hold();
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h180; dma_wdata = 32'h0BAD_0180;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1) $display("FAIL hold_enter_gnt: got %b expected 1", dma_gnt); else passed++;
        step();
        dma_req = 0;
        core_req = 1; core_we = 1; core_addr = 32'h44; core_wdata = 32'h5555_5555;
        @(negedge clk);
        total++; if (core_stall !== 1'b1 || mem_we !== 1'b0 || dma_gnt !== 1'b0)
            $display("FAIL hold_idle: got stall=%b we=%b gnt=%b expected 1/0/0", core_stall, mem_we, dma_gnt); else passed++;
        step();
        total++; if (mem[32'h44 >> 2] !== 32'h0) $display("FAIL hold_no_write: got %h expected 00000000", mem[32'h44 >> 2]); else passed++;
        dma_lock = 0;
        step();
        @(negedge clk);
        total++; if (core_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h44)
            $display("FAIL hold_exit: got stall=%b we=%b addr=%h expected 0/1/00000044", core_stall, mem_we, mem_addr); else passed++;
        step();
        idle_inputs();
        total++; if (mem[32'h44 >> 2] !== 32'h5555_5555) $display("FAIL hold_core_store: got %h expected 55555555", mem[32'h44 >> 2]); else passed++;
    endtask

    task automatic test_write_gating();
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'hB0;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1) $display("FAIL gate_dma_gnt: got %b expected 1", dma_gnt); else passed++;
        step();
        core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h2222_2222;
        dma_addr = 32'h204; dma_wdata = 32'hB1; dma_lock = 0;
        @(negedge clk);
        total++; if (core_stall !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'hB1)
            $display("FAIL gate_loser: got stall=%b addr=%h wdata=%h expected 1/00000204/000000b1", core_stall, mem_addr, mem_wdata); else passed++;
        step();
        total++; if (mem[32'h40 >> 2] !== 32'h1111_1111) $display("FAIL gate_unchanged: got %h expected 11111111", mem[32'h40 >> 2]); else passed++;
        dma_req = 0; dma_we = 0;
        @(negedge clk);
        total++; if (core_stall !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h2222_2222)
            $display("FAIL gate_winner: got stall=%b we=%b wdata=%h expected 0/1/22222222", core_stall, mem_we, mem_wdata); else passed++;
        step();
        idle_inputs();
        total++; if (mem[32'h40 >> 2] !== 32'h2222_2222) $display("FAIL gate_lands: got %h expected 22222222", mem[32'h40 >> 2]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h20 >> 2] = 32'hDEADBEEF;
        mem[32'h24 >> 2] = 32'hCAFEF00D;
        mem[32'h40 >> 2] = 32'h1111_1111;
        test_reset();
        test_core_load();
        test_fairness();
        test_dma_lock();
        test_lock_hold();
        test_write_gating();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
